// File: rtl/ser_arbiter.sv
// ser_arbiter: round-robin arbiter that shares one 32-to-8 serializer among N_REQ requesters.
// Define SER_ARB_TIMEOUT_EN to compile in the WAIT-state watchdog that drives err_o.
module ser_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [32*N_REQ-1:0]   data_i,
  output logic [N_REQ-1:0]      ack_o,
  output logic                  busy_o,
  output logic [ID_W-1:0]       grant_id_o,
  output logic                  ser_cin,
  output logic [31:0]           ser_din,
  input  logic                  ser_done,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic              ser_cin_q, ser_cin_d;
  logic [31:0]       ser_din_q, ser_din_d;
  logic [ID_W-1:0]   winner_s;
  logic              found_s;
  logic [31:0]       data_arr_s [N_REQ];

`ifdef SER_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  // Unpack the flat payload bus into one word per requester.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      data_arr_s[k] = data_i[32*k +: 32];
    end
  end

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found_s && req_i[ID_W'((int'(last_q) + i) % N_REQ)]) begin
        winner_s = ID_W'((int'(last_q) + i) % N_REQ);
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    busy_d    = busy_q;
    grant_d   = grant_q;
    last_d    = last_q;
    ser_cin_d = 1'b0;
    ser_din_d = ser_din_q;
`ifdef SER_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_i != '0) begin
          state_d   = LAUNCH;
          grant_d   = winner_s;
          ser_din_d = data_arr_s[winner_s];
          ser_cin_d = 1'b1;
          busy_d    = 1'b1;
        end else begin
          busy_d    = 1'b0;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
`ifdef SER_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (ser_done) begin
          state_d = ACK;
          for (int k = 0; k < N_REQ; k++) begin
            ack_d[k] = (grant_q == ID_W'(k));
          end
`ifdef SER_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Watchdog expiry still completes the handshake, flagged by err_o.
          state_d = ACK;
          err_d   = 1'b1;
          for (int k = 0; k < N_REQ; k++) begin
            ack_d[k] = (grant_q == ID_W'(k));
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`else
        end else begin
          state_d = WAIT;
        end
`endif
      end
      ACK: begin
        state_d = IDLE;
        last_d  = grant_q;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      grant_q   <= '0;
      last_q    <= ID_W'(N_REQ - 1);
      ser_cin_q <= 1'b0;
      ser_din_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      ser_cin_q <= ser_cin_d;
      ser_din_q <= ser_din_d;
    end
  end

`ifdef SER_ARB_TIMEOUT_EN
  // Watchdog counter and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign ack_o      = ack_q;
  assign busy_o     = busy_q;
  assign grant_id_o = grant_q;
  assign ser_cin    = ser_cin_q;
  assign ser_din    = ser_din_q;

endmodule

// File: tb/tb_ser_arbiter.sv
// Self-checking bench for ser_arbiter: transaction-level round-robin model, randomized traffic.
module tb_ser_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_i;
  logic [127:0] data_i;
  logic [3:0]   ack_o;
  logic         busy_o;
  logic [1:0]   grant_id_o;
  logic         ser_cin;
  logic [31:0]  ser_din;
  logic         ser_done;
  logic         err_o;

  int           n_chk;
  int           n_pass;
  int           model_last;
  logic [31:0]  pay [4];
  int           grant_hist [$];

  ser_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .data_i     (data_i),
    .ack_o      (ack_o),
    .busy_o     (busy_o),
    .grant_id_o (grant_id_o),
    .ser_cin    (ser_cin),
    .ser_din    (ser_din),
    .ser_done   (ser_done),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data;
    data_i = {pay[3], pay[2], pay[1], pay[0]};
  endtask

  // Reference arbitration: first requester found after the previous winner, wrapping.
  function automatic int rr_pick(input logic [3:0] req, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (req[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  // One complete transfer: arbitration, launch, dly WAIT cycles, done, ack, back to IDLE.
  task automatic do_xfer(input logic [3:0] req, input logic [3:0] mid_req, input int dly, input bit rnd_data);
    int w;
    logic [31:0] exp_din;
    logic [3:0] exp_ack;
    req_i = req;
    w = rr_pick(req, model_last);
    exp_din = pay[w];
    tick;
    n_chk++; if (ser_cin !== 1'b1) $display("FAIL launch_cin: got %b want 1", ser_cin); else n_pass++;
    n_chk++; if (busy_o !== 1'b1) $display("FAIL launch_busy: got %b want 1", busy_o); else n_pass++;
    n_chk++; if (grant_id_o !== 2'(w)) $display("FAIL grant_id: got %0d want %0d", grant_id_o, w); else n_pass++;
    n_chk++; if (ser_din !== exp_din) $display("FAIL launch_din: got %h want %h", ser_din, exp_din); else n_pass++;
    n_chk++; if (ack_o !== 4'b0000) $display("FAIL launch_ack: got %b want 0000", ack_o); else n_pass++;
    req_i = mid_req;
    if (rnd_data) begin
      for (int k = 0; k < 4; k++) pay[k] = $urandom;
      set_data;
    end
    tick;
    n_chk++; if (ser_cin !== 1'b0) $display("FAIL wait_cin: got %b want 0", ser_cin); else n_pass++;
    n_chk++; if (ser_din !== exp_din) $display("FAIL wait_din: got %h want %h", ser_din, exp_din); else n_pass++;
    repeat (dly) begin
      tick;
      n_chk++;
      if (ack_o !== 4'b0000 || ser_cin !== 1'b0 || busy_o !== 1'b1)
        $display("FAIL wait_quiet: got ack=%b cin=%b busy=%b want ack=0000 cin=0 busy=1", ack_o, ser_cin, busy_o);
      else n_pass++;
    end
    ser_done = 1'b1;
    tick;
    ser_done = 1'b0;
    exp_ack = 4'b0001 << w;
    n_chk++; if (ack_o !== exp_ack) $display("FAIL ack: got %b want %b", ack_o, exp_ack); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL ack_err: got %b want 0", err_o); else n_pass++;
    n_chk++; if (ser_din !== exp_din) $display("FAIL ack_din: got %h want %h", ser_din, exp_din); else n_pass++;
    tick;
    n_chk++;
    if (ack_o !== 4'b0000 || busy_o !== 1'b0)
      $display("FAIL post_ack: got ack=%b busy=%b want ack=0000 busy=0", ack_o, busy_o);
    else n_pass++;
    model_last = w;
    grant_hist.push_back(w);
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    model_last = 3;
  endtask

  task automatic test_reset;
    req_i = 4'b0000;
    ser_done = 1'b0;
    for (int k = 0; k < 4; k++) pay[k] = 32'h0;
    set_data;
    apply_reset;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
    n_chk++; if (ack_o !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", ack_o); else n_pass++;
    n_chk++; if (ser_cin !== 1'b0) $display("FAIL reset_cin: got %b want 0", ser_cin); else n_pass++;
    n_chk++; if (ser_din !== 32'h0) $display("FAIL reset_din: got %h want 0", ser_din); else n_pass++;
    n_chk++; if (grant_id_o !== 2'd0) $display("FAIL reset_grant: got %0d want 0", grant_id_o); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else n_pass++;
  endtask

  task automatic test_single;
    pay[0] = 32'hDEADBEEF;
    set_data;
    do_xfer(4'b0001, 4'b0000, 4, 1'b0);
  endtask

  task automatic test_rr_all;
    apply_reset;
    pay[0] = 32'h11111111; pay[1] = 32'h22222222;
    pay[2] = 32'h33333333; pay[3] = 32'h44444444;
    set_data;
    grant_hist.delete();
    for (int i = 0; i < 4; i++) do_xfer(4'b1111, 4'b1111, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (grant_hist[i] != i) $display("FAIL rr_order: slot %0d got %0d want %0d", i, grant_hist[i], i); else n_pass++;
    end
    req_i = 4'b0000;
  endtask

  task automatic test_alternate;
    grant_hist.delete();
    for (int i = 0; i < 6; i++) do_xfer(4'b1010, 4'b1010, 1 + i % 3, 1'b0);
    for (int i = 1; i < 6; i++) begin
      n_chk++;
      if (grant_hist[i] == grant_hist[i-1] || (grant_hist[i] != 1 && grant_hist[i] != 3))
        $display("FAIL alternate: slot %0d got %0d after %0d", i, grant_hist[i], grant_hist[i-1]);
      else n_pass++;
    end
    req_i = 4'b0000;
  endtask

  task automatic test_random;
    logic [3:0] cur;
    logic [3:0] nxt;
    cur = 4'($urandom_range(1, 15));
    for (int i = 0; i < 30; i++) begin
      nxt = 4'($urandom_range(1, 15));
      do_xfer(cur, nxt, $urandom_range(0, 5), 1'b1);
      cur = nxt;
    end
    req_i = 4'b0000;
  endtask

  task automatic test_reset_in_wait;
    pay[1] = 32'hCAFE0001; pay[3] = 32'hCAFE0003;
    set_data;
    req_i = 4'b0010;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_last = 3;
    req_i = 4'b0000;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL rstwait_busy: got %b want 0", busy_o); else n_pass++;
    n_chk++; if (ack_o !== 4'b0000) $display("FAIL rstwait_ack: got %b want 0000", ack_o); else n_pass++;
    n_chk++; if (ser_din !== 32'h0) $display("FAIL rstwait_din: got %h want 0", ser_din); else n_pass++;
    tick;
    n_chk++; if (ack_o !== 4'b0000) $display("FAIL rstwait_ack2: got %b want 0000", ack_o); else n_pass++;
    do_xfer(4'b1000, 4'b0000, 3, 1'b0);
  endtask

  task automatic test_idle_done;
    req_i = 4'b0000;
    ser_done = 1'b1;
    tick;
    ser_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (busy_o !== 1'b0 || ack_o !== 4'b0000 || ser_cin !== 1'b0)
        $display("FAIL idle_done: got busy=%b ack=%b cin=%b want 0/0000/0", busy_o, ack_o, ser_cin);
      else n_pass++;
      tick;
    end
    do_xfer(4'b0100, 4'b0000, 0, 1'b1);
  endtask

  task automatic test_timeout;
    int w;
    logic [3:0] exp_ack;
`ifdef SER_ARB_TIMEOUT_EN
    for (int pass = 0; pass < 2; pass++) begin
      req_i = 4'b0001;
      w = rr_pick(4'b0001, model_last);
      tick;
      req_i = 4'b0000;
      tick;
      repeat (15) begin
        tick;
        n_chk++;
        if (ack_o !== 4'b0000 || err_o !== 1'b0)
          $display("FAIL to_early: got ack=%b err=%b want 0000/0", ack_o, err_o);
        else n_pass++;
      end
      ser_done = (pass == 1);
      tick;
      ser_done = 1'b0;
      exp_ack = 4'b0001 << w;
      n_chk++; if (ack_o !== exp_ack) $display("FAIL to_ack: got %b want %b", ack_o, exp_ack); else n_pass++;
      n_chk++; if (err_o !== (pass == 0)) $display("FAIL to_err: got %b want %b", err_o, pass == 0); else n_pass++;
      tick;
      n_chk++;
      if (err_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL to_after: got err=%b busy=%b want 0/0", err_o, busy_o);
      else n_pass++;
      model_last = w;
    end
`else
    req_i = 4'b0001;
    w = rr_pick(4'b0001, model_last);
    tick;
    req_i = 4'b0000;
    tick;
    repeat (100) begin
      tick;
      n_chk++;
      if (busy_o !== 1'b1 || err_o !== 1'b0 || ack_o !== 4'b0000)
        $display("FAIL no_timeout: got busy=%b err=%b ack=%b want 1/0/0000", busy_o, err_o, ack_o);
      else n_pass++;
    end
    ser_done = 1'b1;
    tick;
    ser_done = 1'b0;
    exp_ack = 4'b0001 << w;
    n_chk++; if (ack_o !== exp_ack) $display("FAIL late_ack: got %b want %b", ack_o, exp_ack); else n_pass++;
    tick;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL late_idle: got %b want 0", busy_o); else n_pass++;
    model_last = w;
`endif
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    req_i = 4'b0000;
    data_i = 128'h0;
    ser_done = 1'b0;
    test_reset;
    test_single;
    test_rr_all;
    test_alternate;
    test_random;
    test_reset_in_wait;
    test_idle_done;
    test_timeout;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ser_arbiter.md
SER_ARBITER -- requirements
Module: ser_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one 32-to-8 serializer.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, watchdog limit in cycles spent in WAIT (used only when the Configuration macro is defined).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_i  input  N_REQ  per-requester request level; held high until the matching ack_o pulse.
REQ-006 data_i  input  32*N_REQ  per-requester payload; requester k occupies bits [32k+31:32k].
REQ-007 ack_o  output  N_REQ  one-hot, one-cycle pulse marking transfer completion for the granted requester.
REQ-008 busy_o  output  1  high in every state except IDLE.
REQ-009 grant_id_o  output  clog2(N_REQ)  index of the current or most recent winner.
REQ-010 ser_cin  output  1  one-cycle start pulse to the serializer.
REQ-011 ser_din  output  32  payload to the serializer; held stable from LAUNCH until the return to IDLE.
REQ-012 ser_done  input  1  serializer completion flag.
REQ-013 err_o  output  1  one-cycle timeout flag; the port exists in both build variants.

Function
REQ-014 FSM states: IDLE, LAUNCH, WAIT, ACK; encoding is free.
REQ-015 IDLE: if req_i is nonzero, select a winner, latch its data_i into ser_din, set grant_id_o, and go to LAUNCH; otherwise stay in IDLE.
REQ-016 Arbitration is round-robin: the search starts at (last_winner+1) mod N_REQ and wraps; after reset the search starts at requester 0.
REQ-017 LAUNCH: ser_cin=1 for exactly this cycle, then go to WAIT unconditionally.
REQ-018 WAIT: when ser_done=1 is sampled, go to ACK; otherwise stay in WAIT.
REQ-019 ACK: ack_o[grant_id_o]=1 for this cycle only, last_winner is set to grant_id_o, then go to IDLE.
REQ-020 Latency: a request sampled in IDLE at edge n gives ser_cin high in cycle n+1; ser_done sampled at edge m gives ack_o in cycle m+1; the next arbitration is sampled at edge m+2.
REQ-021 ser_done is ignored in IDLE, LAUNCH and ACK.
REQ-022 A req_i that drops mid-transfer does not abort the transfer; ack_o is still issued.
REQ-023 Requests that arrive while busy_o=1 are held pending and are not lost; they are arbitrated at the next IDLE.
REQ-024 ack_o is zero or one-hot in every cycle; ser_cin never pulses twice for one grant.

Reset
REQ-025 rst=1 at an edge forces IDLE, last_winner=N_REQ-1, ack_o=0, busy_o=0, ser_cin=0, ser_din=0, grant_id_o=0, err_o=0 and the timeout counter to 0.
REQ-026 Reset during LAUNCH, WAIT or ACK abandons the transfer and issues no ack_o; the serializer's reset is handled externally.

Configuration
REQ-027 Macro SER_ARB_TIMEOUT_EN compiles in a WAIT-state watchdog.
REQ-028 With the macro defined: a counter clears on entry to WAIT and increments each cycle in WAIT.
- If the counter reaches TIMEOUT_CYCLES with ser_done still 0, the FSM goes to ACK.
- In that ACK cycle, err_o=1 and ack_o pulses at the same time.
- If ser_done and the timeout occur in the same cycle, ser_done wins and err_o stays 0.
REQ-029 Without the macro: no counter exists, err_o is tied to 0, and WAIT waits for ser_done indefinitely.

Verification
REQ-030 Single request: req_i=0001, data_i[31:0]=32'hDEADBEEF -> ser_cin pulses one cycle later with ser_din=DEADBEEF; ser_done 4 cycles later -> ack_o=0001 for one cycle.
REQ-031 After reset, req_i=1111 held with payloads 11111111/22222222/33333333/44444444 -> serializer sees ser_din in order 11111111, 22222222, 33333333, 44444444, with acks 0001, 0010, 0100, 1000.
REQ-032 req_i=1010 held continuously -> grants alternate 1, 3, 1, 3, and requester 1 is never granted twice in a row.
REQ-033 rst pulsed for one cycle during WAIT -> next cycle busy_o=0, no ack_o, ser_din=0; a following req_i=1000 is granted to requester 3.
REQ-034 ser_done=1 pulsed while IDLE with req_i=0 -> no state change, busy_o stays 0, no ack_o.
REQ-035 Timeout test with ser_done held at 0:
- With SER_ARB_TIMEOUT_EN defined: err_o and ack_o pulse together after 16 WAIT cycles.
- Without the macro: busy_o stays 1 for 100 cycles and err_o stays 0.
